// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter
// Purpose  : Shares one memory port between fetch (i_) and load/store (d_),
//            data-priority with a fetch starvation guard, one outstanding txn.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_wstrb,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            err_stray
);

    localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_pick_i;
    logic                w_i_gnt;
    logic                w_d_gnt;
    logic                r_owner_d;
    logic [c_CNT_W-1:0]  r_starve_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [XLEN-1:0]     r_mem_addr;
    logic [XLEN-1:0]     r_mem_wdata;
    logic [3:0]          r_mem_wstrb;
    logic                r_i_rvalid;
    logic [XLEN-1:0]     r_i_rdata;
    logic                r_d_rvalid;
    logic [XLEN-1:0]     r_d_rdata;
    logic                r_err_stray;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Fetch wins only when alone or once data has starved it STARVE_LIMIT times.
    always_comb begin
        w_next   = r_state;
        w_i_gnt  = 1'b0;
        w_d_gnt  = 1'b0;
        w_pick_i = i_req && (!d_req || (r_starve_cnt == c_LIMIT));
        case (r_state)
            ST_IDLE: begin
                w_i_gnt = w_pick_i;
                w_d_gnt = d_req && !w_pick_i;
                if (w_i_gnt || w_d_gnt) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    w_next = ST_RSP;
                end
            end
            ST_RSP: begin
                if (mem_rvalid) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner_d    <= 1'b0;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_i_rvalid   <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rvalid   <= 1'b0;
            r_d_rdata    <= '0;
            r_err_stray  <= 1'b0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;

            if (mem_rvalid && (r_state != ST_RSP)) begin
                r_err_stray <= 1'b1;
            end

            if (r_state == ST_IDLE) begin
                if (w_i_gnt) begin
                    r_starve_cnt <= '0;
                end else if (w_d_gnt && i_req) begin
                    if (r_starve_cnt != c_LIMIT) begin
                        r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
                    end
                end else if (!i_req) begin
                    r_starve_cnt <= '0;
                end
            end

            if (w_i_gnt) begin
                r_owner_d   <= 1'b0;
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= i_addr;
                r_mem_wdata <= '0;
                r_mem_wstrb <= '0;
            end else if (w_d_gnt) begin
                r_owner_d   <= 1'b1;
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_mem_wstrb <= d_wstrb;
            end

            if ((r_state == ST_REQ) && mem_gnt) begin
                r_mem_req <= 1'b0;
            end

            if ((r_state == ST_RSP) && mem_rvalid) begin
                if (r_owner_d) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= r_mem_we ? '0 : mem_rdata;
                end else begin
                    r_i_rvalid <= 1'b1;
                    r_i_rdata  <= mem_rdata;
                end
            end
        end
    end

    assign i_gnt     = w_i_gnt;
    assign d_gnt     = w_d_gnt;
    assign i_rvalid  = r_i_rvalid;
    assign i_rdata   = r_i_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign err_stray = r_err_stray;

endmodule
`default_nettype wire
